// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
//  uart_pkg : shared types, defaults and helper for the UART TX arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int C_OS_DEFAULT      = 16;
  localparam int C_SB_TICK_DEFAULT = 16;

  // Ceiling log2, never below 1 so the result can always size a register.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ============================================================================
//  rr_arbiter : combinational round-robin winner search starting after i_last
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        i_req,
  input  logic [clog2(NREQ)-1:0] i_last,
  output logic [clog2(NREQ)-1:0] o_winner,
  output logic                   o_any
);

  localparam int C_LW = clog2(NREQ);

  int              w_idx;
  logic [NREQ-1:0] w_sh;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    w_sh     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % NREQ;
      w_sh  = i_req >> w_idx;
      if (w_sh[0]) o_winner = C_LW'(w_idx);
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  uart_tx_arbiter : round-robin shared UART transmitter, NREQ byte sources
//  Optional even parity bit when UART_TX_PARITY_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int SB_TICK = C_SB_TICK_DEFAULT,
  parameter int OS      = C_OS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_s_tick,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DBIT-1:0]   i_din,
  output logic [NREQ-1:0]        o_gnt,
  output logic [clog2(NREQ)-1:0] o_owner,
  output logic                   o_busy,
  output logic                   o_tx_done_tick,
  output logic                   o_tx
);

  localparam int C_OW = clog2(NREQ);
  localparam int C_SW = clog2((OS > SB_TICK) ? OS : SB_TICK);
  localparam int C_NW = clog2(DBIT);

  state_t            r_state;
  logic [C_SW-1:0]   r_s;
  logic [C_NW-1:0]   r_n;
  logic [DBIT-1:0]   r_b;
  logic [C_OW-1:0]   r_last;
  logic [NREQ-1:0]   r_gnt;
  logic [C_OW-1:0]   r_owner;
  logic              r_busy;
  logic              r_done;
  logic              r_tx;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
`endif

  logic [C_OW-1:0]   w_winner;
  logic              w_any;
  logic [DBIT-1:0]   w_sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_sel = i_din[w_winner*DBIT +: DBIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_last  <= C_OW'(NREQ - 1);
      r_gnt   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Grant edge ignores s_tick; the start bit counts from the next tick.
          if (w_any) begin
            r_b     <= w_sel;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_gnt   <= NREQ'(1) << w_winner;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_s     <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^w_sel;
`endif
            r_state <= START;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (r_s == C_SW'(OS - 1)) begin
              r_s     <= '0;
              r_n     <= '0;
              r_tx    <= r_b[0];
              r_state <= DATA;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (r_s == C_SW'(OS - 1)) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == C_NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                r_tx    <= r_par;
                r_state <= PARITY;
`else
                r_tx    <= 1'b1;
                r_state <= STOP;
`endif
              end else begin
                r_n  <= r_n + 1'b1;
                r_tx <= r_b[1];
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (i_s_tick) begin
            if (r_s == C_SW'(OS - 1)) begin
              r_s     <= '0;
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_s_tick) begin
            if (r_s == C_SW'(SB_TICK - 1)) begin
              r_s     <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt          = r_gnt;
  assign o_owner        = r_owner;
  assign o_busy         = r_busy;
  assign o_tx_done_tick = r_done;
  assign o_tx           = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

`ifdef UART_TX_PARITY_EN
  localparam int FLEN    = 176;
  localparam int STOPIDX = 10;
`else
  localparam int FLEN    = 160;
  localparam int STOPIDX = 9;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        s_tick = 1'b0;
  logic [3:0]  req    = 4'b0;
  logic [31:0] din    = 32'h0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        done;
  logic        tx;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .SB_TICK(16), .OS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_s_tick       (s_tick),
    .i_req          (req),
    .i_din          (din),
    .o_gnt          (gnt),
    .o_owner        (owner),
    .o_busy         (busy),
    .o_tx_done_tick (done),
    .o_tx           (tx)
  );

  always #5 clk = ~clk;

  // One s_tick every 4 clocks, changed on the falling edge.
  initial begin : tick_gen
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % 4;
      s_tick = (phase == 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for a grant, then records the line at mid-bit of every frame bit.
  task automatic capture_frame(input logic drop, output logic to,
                               output logic [3:0] g, output logic [1:0] own,
                               output logic [10:0] bits, output int len,
                               output logic gok, output logic ba);
    int c;
    int wc;
    to = 1'b0; g = '0; own = '0; bits = '1; len = 0; gok = 1'b0; ba = 1'b1;
    wc = 0;
    do begin
      @(posedge clk); #1; wc++;
    end while (gnt == 4'b0 && wc < 3000);
    if (gnt == 4'b0) begin
      to = 1'b1;
      return;
    end
    g   = gnt;
    own = owner;
    if (drop) begin
      @(negedge clk);
      req       = 4'b0;
      din[7:0]  = ~din[7:0];
    end
    c  = 0;
    wc = 0;
    while (wc < 1000) begin
      @(posedge clk); #1; wc++;
      if (wc == 1) gok = (gnt == 4'b0);
      if (s_tick) begin
        c++;
        if (c % 16 == 8 && c / 16 < 11) bits[c/16] = tx;
      end
      if (done) begin
        len = c;
        ba  = busy;
        return;
      end
    end
    to = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
    total++; if (gnt !== 4'b0)  begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", owner); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    @(negedge clk); reset = 1'b0;
    repeat (10) @(posedge clk); #1;
    total++;
    if ({tx, busy, gnt} !== 6'b100000) begin
      bad++; $display("FAIL idle_noreq: got tx/busy/gnt=%b want 100000", {tx, busy, gnt});
    end
  endtask

  task automatic test_single_frame();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    do_reset();
    din = 32'h000000A5;
    req = 4'b0001;
    capture_frame(1'b0, to, g, own, bits, len, gok, ba);
    req = 4'b0;
    total++; if (to !== 1'b0)      begin bad++; $display("FAIL single_timeout: got %b want 0", to); end
    total++; if (g !== 4'b0001)    begin bad++; $display("FAIL single_gnt: got %b want 0001", g); end
    total++; if (own !== 2'd0)     begin bad++; $display("FAIL single_owner: got %0d want 0", own); end
    total++; if (gok !== 1'b1)     begin bad++; $display("FAIL single_gnt_pulse: got %b want 1", gok); end
    total++; if (bits[0] !== 1'b0) begin bad++; $display("FAIL single_start: got %b want 0", bits[0]); end
    total++; if (bits[8:1] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", bits[8:1]); end
    total++; if (bits[STOPIDX] !== 1'b1) begin bad++; $display("FAIL single_stop: got %b want 1", bits[STOPIDX]); end
    total++; if (len !== FLEN)     begin bad++; $display("FAIL single_len: got %0d want %0d", len, FLEN); end
    total++; if (ba !== 1'b0)      begin bad++; $display("FAIL single_busy_end: got %b want 0", ba); end
    repeat (5) @(posedge clk); #1;
    total++;
    if ({tx, busy, gnt} !== 6'b100000) begin
      bad++; $display("FAIL single_idle_after: got tx/busy/gnt=%b want 100000", {tx, busy, gnt});
    end
  endtask

  task automatic test_round_robin();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    int exp_o[5];
    exp_o = '{0, 1, 2, 3, 0};
    do_reset();
    din = 32'h44332211;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      capture_frame(1'b0, to, g, own, bits, len, gok, ba);
      total++;
      if (to !== 1'b0 || g !== 4'(1 << exp_o[k])) begin
        bad++; $display("FAIL rr_gnt[%0d]: got %b want %b (timeout %b)", k, g, 4'(1 << exp_o[k]), to);
      end
      total++;
      if (own !== 2'(exp_o[k])) begin bad++; $display("FAIL rr_owner[%0d]: got %0d want %0d", k, own, exp_o[k]); end
      total++;
      if (bits[8:1] !== din[exp_o[k]*8 +: 8]) begin
        bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, bits[8:1], din[exp_o[k]*8 +: 8]);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_fairness();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    int exp_a[4];
    int exp_b[3];
    exp_a = '{0, 1, 0, 1};
    exp_b = '{0, 2, 0};
    do_reset();
    din = 32'h00006699;
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      capture_frame(1'b0, to, g, own, bits, len, gok, ba);
      total++;
      if (to !== 1'b0 || own !== 2'(exp_a[k]) || bits[8:1] !== din[exp_a[k]*8 +: 8]) begin
        bad++; $display("FAIL fair_0011[%0d]: got owner %0d data %h want owner %0d data %h",
                        k, own, bits[8:1], exp_a[k], din[exp_a[k]*8 +: 8]);
      end
    end
    do_reset();
    din = 32'h00770055;
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      capture_frame(1'b0, to, g, own, bits, len, gok, ba);
      total++;
      if (to !== 1'b0 || g !== 4'(1 << exp_b[k]) || bits[8:1] !== din[exp_b[k]*8 +: 8]) begin
        bad++; $display("FAIL fair_0101[%0d]: got gnt %b data %h want gnt %b data %h",
                        k, g, bits[8:1], 4'(1 << exp_b[k]), din[exp_b[k]*8 +: 8]);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_drop();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    logic extra;
    do_reset();
    din = 32'h0000003C;
    req = 4'b0001;
    capture_frame(1'b1, to, g, own, bits, len, gok, ba);
    total++; if (to !== 1'b0 || g !== 4'b0001) begin bad++; $display("FAIL drop_gnt: got %b want 0001", g); end
    total++; if (bits[8:1] !== 8'h3C) begin bad++; $display("FAIL drop_data: got %h want 3c", bits[8:1]); end
    total++; if (len !== FLEN) begin bad++; $display("FAIL drop_len: got %0d want %0d", len, FLEN); end
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0 || busy !== 1'b0 || tx !== 1'b1) extra = 1'b1;
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL drop_regrant: got %b want 0", extra); end
  endtask

  task automatic test_reset_mid_frame();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    int c;
    int wc;
    do_reset();
    din = 32'h5A0000C3;
    req = 4'b0001;
    wc = 0;
    do begin
      @(posedge clk); #1; wc++;
    end while (gnt == 4'b0 && wc < 100);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
    c  = 0;
    wc = 0;
    while (c < 69 && wc < 1000) begin
      @(posedge clk); #1; wc++;
      if (s_tick) c++;
    end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b want 0", tx); end
    reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (gnt !== 4'b0)  begin bad++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
    req = 4'b1000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    capture_frame(1'b0, to, g, own, bits, len, gok, ba);
    req = 4'b0;
    total++; if (to !== 1'b0 || g !== 4'b1000) begin bad++; $display("FAIL mid_after_gnt: got %b want 1000", g); end
    total++; if (own !== 2'd3) begin bad++; $display("FAIL mid_after_owner: got %0d want 3", own); end
    total++;
    if (bits[0] !== 1'b0 || bits[8:1] !== 8'h5A || bits[STOPIDX] !== 1'b1 || len !== FLEN) begin
      bad++; $display("FAIL mid_after_frame: got start %b data %h stop %b len %0d want 0 5a 1 %0d",
                      bits[0], bits[8:1], bits[STOPIDX], len, FLEN);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic to, gok, ba; logic [3:0] g; logic [1:0] own; logic [10:0] bits; int len;
    logic [7:0] vec[2];
    logic       exp_p[2];
    vec   = '{8'h07, 8'h03};
    exp_p = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      din = {24'h0, vec[k]};
      req = 4'b0001;
      capture_frame(1'b0, to, g, own, bits, len, gok, ba);
      req = 4'b0;
      total++;
      if (to !== 1'b0 || bits[8:1] !== vec[k]) begin
        bad++; $display("FAIL par_data[%0d]: got %h want %h", k, bits[8:1], vec[k]);
      end
      total++;
      if (bits[9] !== exp_p[k]) begin bad++; $display("FAIL par_bit[%0d]: got %b want %b", k, bits[9], exp_p[k]); end
      total++;
      if (len !== 176 || bits[10] !== 1'b1) begin
        bad++; $display("FAIL par_len[%0d]: got len %0d stop %b want 176 1", k, len, bits[10]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fairness();
    test_drop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
